inventory_bank: RTL and testbench
=================================

Name: inventory_bank

Overview:
- Parametrised successor to the single-decrement stock tracker. Holds per-item stock counts for ITEM_COUNT slots of QTY_W bits each.
- Services vend requests through a req/ack/nack handshake, accepts per-item and global restocks, and flags sold-out and low-stock per item.
- Sits between the vend controller FSM and the dispenser/display logic.

Parameters:
- ITEM_COUNT, 8: number of item slots.
- SEL_W, 3: item index width; must satisfy 2**SEL_W >= ITEM_COUNT.
- QTY_W, 6: stock counter width.
- START_QTY, 10: per-item count loaded on reset.
- MAX_QTY, 20: restock ceiling; must be <= 2**QTY_W-1.
- LOW_THRESH, 2: item is low-stock when 0 < count <= LOW_THRESH.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- vend_req, input, 1: vend request, level; held until ack/nack seen.
- vend_item, input, SEL_W: item to vend; sampled when the request is accepted.
- vend_ack, output, 1: one-cycle pulse; item was decremented.
- vend_nack, output, 1: one-cycle pulse; item was empty or the index was out of range.
- restock_req, input, 1: add restock_qty to restock_item; honoured only when restock_ready=1.
- restock_item, input, SEL_W: restock target index.
- restock_qty, input, QTY_W: amount to add.
- restock_all, input, 1: set every item to MAX_QTY; honoured only when restock_ready=1.
- restock_ready, output, 1: high in IDLE.
- query_item, input, SEL_W: combinational readback index.
- stock_level, output, QTY_W: count of query_item; 0 if the index is out of range.
- sold_out, output, 1: stock_level==0.
- stock_available, output, ITEM_COUNT: bit i = count[i]!=0.
- low_stock, output, ITEM_COUNT: bit i = 0<count[i]<=LOW_THRESH.
- busy, output, 1: FSM not in IDLE.

Behaviour:
- Reset (async): every count = START_QTY; FSM = IDLE; vend_ack=0, vend_nack=0, busy=0, restock_ready=1. Audit counters (if present) = 0.
- FSM states: IDLE, CHECK, DONE.
- IDLE:
  - Priority order: restock_all, then restock_req, then vend_req.
  - If restock_all or restock_req is active, apply it this edge and stay in IDLE. A vend_req asserted in the same cycle waits; it is accepted on the next cycle it is seen in IDLE without a restock.
  - Else if vend_req: latch vend_item into sel_q and go to CHECK.
- CHECK, exactly one cycle:
  - If sel_q < ITEM_COUNT and count[sel_q] != 0: count[sel_q] -= 1 and pulse vend_ack.
  - Otherwise pulse vend_nack and leave counts unchanged.
  - Go to DONE.
  - Ack/nack is registered and appears the cycle after CHECK is entered, i.e. 2 cycles after vend_req is first sampled high in IDLE.
- DONE: wait until vend_req==0, then go to IDLE. This enforces one vend per request assertion.
- Restock arithmetic:
  - count = min(count + restock_qty, MAX_QTY), computed at QTY_W+1 bits, so there is no wrap.
  - restock_item >= ITEM_COUNT is ignored.
  - restock_qty=0 is a no-op.
- Restock requests in CHECK or DONE are ignored, not queued.
- Decrement never goes below 0.
- stock_level, sold_out, stock_available and low_stock are combinational from the registered counts. They update the cycle after a count change.
- Reset asserted mid-transaction aborts it: no ack/nack is emitted and counts return to START_QTY.

Optional Feature:
- Macro: INVENTORY_AUDIT_EN.
- When defined:
  - Per-item 16-bit vend counters increment on each vend_ack for that item and saturate at 0xFFFF.
  - Extra output port audit_count [15:0] shows the counter for query_item; 0 if the index is out of range.
  - Extra input audit_clr (1 bit) clears all counters synchronously. audit_clr has priority over an increment in the same cycle.
- When undefined: neither port exists and no counters are built. All other behaviour is identical.

Test Plan:
- Reset release, query_item=3 -> stock_level=10; stock_available=8'hFF; low_stock=0; restock_ready=1.
- vend_req=1, vend_item=2, held -> vend_ack pulses exactly once, 2 cycles after request. count[2]=9. No second ack while vend_req stays high; the next vend needs vend_req low for at least 1 cycle.
- 10 vends of item 5 -> low_stock[5] rises when count reaches 2, stock_available[5] clears at 0. The 11th vend gives vend_nack and count stays 0.
- count[1]=18, restock item 1 with qty 5 -> count 20 (clamped). Then restock_all while busy=1 -> ignored; restock_all in IDLE -> all counts 20.
- vend_req and restock_req both asserted in IDLE -> restock applied first, vend accepted the following cycle. vend_item=7 with ITEM_COUNT=6 -> vend_nack.
- rst pulsed during CHECK -> no ack/nack, counts = 10. With INVENTORY_AUDIT_EN: 3 acks on item 0 -> audit_count=3; audit_clr -> 0.

Source files
------------

// File: rtl/inventory_bank.sv
// rtl/inventory_bank.sv - per-item stock bank with vend req/ack/nack handshake and restock.
// Optional per-item vend audit counters when INVENTORY_AUDIT_EN is defined.
module inventory_bank #(
  parameter int ITEM_COUNT = 8,
  parameter int SEL_W      = 3,
  parameter int QTY_W      = 6,
  parameter int START_QTY  = 10,
  parameter int MAX_QTY    = 20,
  parameter int LOW_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vend_req,
  input  logic [SEL_W-1:0]      vend_item,
  output logic                  vend_ack,
  output logic                  vend_nack,
  input  logic                  restock_req,
  input  logic [SEL_W-1:0]      restock_item,
  input  logic [QTY_W-1:0]      restock_qty,
  input  logic                  restock_all,
  output logic                  restock_ready,
  input  logic [SEL_W-1:0]      query_item,
  output logic [QTY_W-1:0]      stock_level,
  output logic                  sold_out,
  output logic [ITEM_COUNT-1:0] stock_available,
  output logic [ITEM_COUNT-1:0] low_stock,
  output logic                  busy
`ifdef INVENTORY_AUDIT_EN
  ,
  input  logic                  audit_clr,
  output logic [15:0]           audit_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [QTY_W-1:0] r_count [ITEM_COUNT];
  logic [SEL_W-1:0] r_sel_q;
  logic             r_ack;
  logic             r_nack;
  logic             w_sel_ok;
  logic [QTY_W-1:0] w_rs_cnt;
  logic [QTY_W:0]   w_sum;
  logic [QTY_W-1:0] w_restock_val;

  // Out-of-range indices never match any slot, so they fall through as empty.
  always_comb begin
    w_sel_ok = 1'b0;
    w_rs_cnt = '0;
    for (int i = 0; i < ITEM_COUNT; i++) begin
      if (r_sel_q == SEL_W'(i) && r_count[i] != '0) w_sel_ok = 1'b1;
      if (restock_item == SEL_W'(i)) w_rs_cnt = r_count[i];
    end
    w_sum         = {1'b0, w_rs_cnt} + {1'b0, restock_qty};
    w_restock_val = (w_sum > (QTY_W+1)'(MAX_QTY)) ? QTY_W'(MAX_QTY) : w_sum[QTY_W-1:0];
  end

  always_comb begin
    w_next        = r_state;
    busy          = (r_state != S_IDLE);
    restock_ready = (r_state == S_IDLE);
    case (r_state)
      S_IDLE:  if (!restock_all && !restock_req && vend_req) w_next = S_CHECK;
      S_CHECK: w_next = S_DONE;
      S_DONE:  if (!vend_req) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sel_q <= '0;
      r_ack   <= 1'b0;
      r_nack  <= 1'b0;
      for (int i = 0; i < ITEM_COUNT; i++) r_count[i] <= QTY_W'(START_QTY);
    end else begin
      r_state <= w_next;
      r_ack   <= 1'b0;
      r_nack  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (restock_all) begin
            for (int i = 0; i < ITEM_COUNT; i++) r_count[i] <= QTY_W'(MAX_QTY);
          end else if (restock_req) begin
            for (int i = 0; i < ITEM_COUNT; i++)
              if (restock_item == SEL_W'(i)) r_count[i] <= w_restock_val;
          end else if (vend_req) begin
            r_sel_q <= vend_item;
          end
        end
        S_CHECK: begin
          if (w_sel_ok) begin
            for (int i = 0; i < ITEM_COUNT; i++)
              if (r_sel_q == SEL_W'(i)) r_count[i] <= r_count[i] - 1'b1;
            r_ack <= 1'b1;
          end else begin
            r_nack <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign vend_ack  = r_ack;
  assign vend_nack = r_nack;

  always_comb begin
    stock_level = '0;
    for (int i = 0; i < ITEM_COUNT; i++) begin
      if (query_item == SEL_W'(i)) stock_level = r_count[i];
      stock_available[i] = (r_count[i] != '0);
      low_stock[i]       = (r_count[i] != '0) && (r_count[i] <= QTY_W'(LOW_THRESH));
    end
    sold_out = (stock_level == '0);
  end

`ifdef INVENTORY_AUDIT_EN
  logic [15:0] r_audit [ITEM_COUNT];

  // r_sel_q is still held while the ack is visible, so it names the vended slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ITEM_COUNT; i++) r_audit[i] <= '0;
    end else if (audit_clr) begin
      for (int i = 0; i < ITEM_COUNT; i++) r_audit[i] <= '0;
    end else if (r_ack) begin
      for (int i = 0; i < ITEM_COUNT; i++)
        if (r_sel_q == SEL_W'(i) && r_audit[i] != 16'hFFFF) r_audit[i] <= r_audit[i] + 16'd1;
    end
  end

  always_comb begin
    audit_count = '0;
    for (int i = 0; i < ITEM_COUNT; i++)
      if (query_item == SEL_W'(i)) audit_count = r_audit[i];
  end
`endif

endmodule

// File: tb/tb_inventory_bank.sv
// tb/tb_inventory_bank.sv - directed vector bench for inventory_bank (default and 6-item builds).
// Audit checks are compiled in when INVENTORY_AUDIT_EN is defined.
module tb_inventory_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vend_req = 1'b0;
  logic [2:0] vend_item = '0;
  logic       vend_ack, vend_nack;
  logic       restock_req = 1'b0;
  logic [2:0] restock_item = '0;
  logic [5:0] restock_qty = '0;
  logic       restock_all = 1'b0;
  logic       restock_ready;
  logic [2:0] query_item = '0;
  logic [5:0] stock_level;
  logic       sold_out;
  logic [7:0] stock_available, low_stock;
  logic       busy;

  logic       d6_vend_req = 1'b0;
  logic [2:0] d6_vend_item = '0;
  logic       d6_vend_ack, d6_vend_nack;
  logic       d6_restock_ready, d6_sold_out, d6_busy;
  logic [2:0] d6_query_item = '0;
  logic [5:0] d6_stock_level;
  logic [5:0] d6_stock_available, d6_low_stock;

`ifdef INVENTORY_AUDIT_EN
  logic        audit_clr = 1'b0;
  logic [15:0] audit_count;
  logic [15:0] d6_audit_count;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inventory_bank u_dut (
    .clk(clk), .rst(rst),
    .vend_req(vend_req), .vend_item(vend_item), .vend_ack(vend_ack), .vend_nack(vend_nack),
    .restock_req(restock_req), .restock_item(restock_item), .restock_qty(restock_qty),
    .restock_all(restock_all), .restock_ready(restock_ready),
    .query_item(query_item), .stock_level(stock_level), .sold_out(sold_out),
    .stock_available(stock_available), .low_stock(low_stock), .busy(busy)
`ifdef INVENTORY_AUDIT_EN
    , .audit_clr(audit_clr), .audit_count(audit_count)
`endif
  );

  inventory_bank #(.ITEM_COUNT(6)) u_dut6 (
    .clk(clk), .rst(rst),
    .vend_req(d6_vend_req), .vend_item(d6_vend_item), .vend_ack(d6_vend_ack), .vend_nack(d6_vend_nack),
    .restock_req(1'b0), .restock_item(3'd0), .restock_qty(6'd0),
    .restock_all(1'b0), .restock_ready(d6_restock_ready),
    .query_item(d6_query_item), .stock_level(d6_stock_level), .sold_out(d6_sold_out),
    .stock_available(d6_stock_available), .low_stock(d6_low_stock), .busy(d6_busy)
`ifdef INVENTORY_AUDIT_EN
    , .audit_clr(1'b0), .audit_count(d6_audit_count)
`endif
  );

  typedef struct {
    int         op;      // 0 none, 1 vend, 2 restock
    int         item;
    int         qty;
    int         query;
    int         exp_level;
    logic [7:0] exp_avail;
    logic [7:0] exp_low;
    bit         exp_ack;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_vend(input int item, input bit exp_ack);
    int  n;
    bit  seen;
    vend_item = 3'(item);
    vend_req  = 1'b1;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 10) begin
      tick();
      n++;
      if (vend_ack || vend_nack) seen = 1'b1;
    end
    chk("vend_response_seen", 32'(seen), 32'd1);
    chk("vend_ack_kind", 32'(vend_ack), 32'(exp_ack));
    chk("vend_nack_kind", 32'(vend_nack), 32'(!exp_ack));
    vend_req = 1'b0;
    tick();
  endtask

  initial begin
    vecs.push_back('{0, 0, 0, 3, 10, 8'hFF, 8'h00, 1'b0});
    vecs.push_back('{1, 2, 0, 2, 9,  8'hFF, 8'h00, 1'b1});
    for (int k = 1; k <= 11; k++) begin
      int c;
      c = (10 - k < 0) ? 0 : 10 - k;
      vecs.push_back('{1, 5, 0, 5, c, (c == 0) ? 8'hDF : 8'hFF,
                       (c > 0 && c <= 2) ? 8'h20 : 8'h00, k <= 10});
    end
    vecs.push_back('{2, 1, 8,  1, 18, 8'hDF, 8'h00, 1'b0});
    vecs.push_back('{2, 1, 5,  1, 20, 8'hDF, 8'h00, 1'b0});
    vecs.push_back('{2, 1, 0,  1, 20, 8'hDF, 8'h00, 1'b0});
    vecs.push_back('{2, 3, 63, 3, 20, 8'hDF, 8'h00, 1'b0});
    vecs.push_back('{2, 5, 1,  5, 1,  8'hFF, 8'h20, 1'b0});

    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset_ready", 32'(restock_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ack", 32'({vend_ack, vend_nack}), 32'd0);

    foreach (vecs[v]) begin
      if (vecs[v].op == 1) begin
        do_vend(vecs[v].item, vecs[v].exp_ack);
      end else if (vecs[v].op == 2) begin
        restock_item = 3'(vecs[v].item);
        restock_qty  = 6'(vecs[v].qty);
        restock_req  = 1'b1;
        tick();
        restock_req  = 1'b0;
      end
      query_item = 3'(vecs[v].query);
      #1;
      chk($sformatf("v%0d_level", v), 32'(stock_level), 32'(vecs[v].exp_level));
      chk($sformatf("v%0d_sold_out", v), 32'(sold_out), 32'(vecs[v].exp_level == 0));
      chk($sformatf("v%0d_avail", v), 32'(stock_available), 32'(vecs[v].exp_avail));
      chk($sformatf("v%0d_low", v), 32'(low_stock), 32'(vecs[v].exp_low));
    end

    // Held request: one ack exactly two edges after acceptance, none afterwards.
    vend_item = 3'd2;
    vend_req  = 1'b1;
    tick();
    chk("held_busy_check", 32'(busy), 32'd1);
    chk("held_ack_early", 32'(vend_ack), 32'd0);
    tick();
    chk("held_ack_pulse", 32'(vend_ack), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("held_no_reack_%0d", k), 32'({vend_ack, vend_nack}), 32'd0);
    end
    chk("held_busy_done", 32'(busy), 32'd1);
    vend_req = 1'b0;
    tick();
    chk("held_idle", 32'(busy), 32'd0);
    query_item = 3'd2;
    #1;
    chk("held_level", 32'(stock_level), 32'd8);

    // Restock_all while busy is dropped; in IDLE it loads every slot.
    vend_item = 3'd0;
    vend_req  = 1'b1;
    tick();
    restock_all = 1'b1;
    #1;
    chk("busy_ready_low", 32'(restock_ready), 32'd0);
    tick();
    tick();
    vend_req    = 1'b0;
    restock_all = 1'b0;
    tick();
    query_item = 3'd0;
    #1;
    chk("busy_all_ignored_0", 32'(stock_level), 32'd9);
    query_item = 3'd4;
    #1;
    chk("busy_all_ignored_4", 32'(stock_level), 32'd10);
    restock_all = 1'b1;
    tick();
    restock_all = 1'b0;
    query_item  = 3'd6;
    #1;
    chk("all_level_6", 32'(stock_level), 32'd20);
    chk("all_avail", 32'(stock_available), 32'hFF);
    chk("all_low", 32'(low_stock), 32'h00);

    // Vend and restock together: restock first, vend on the following edge.
    do_vend(4, 1'b1);
    vend_item    = 3'd4;
    vend_req     = 1'b1;
    restock_item = 3'd4;
    restock_qty  = 6'd1;
    restock_req  = 1'b1;
    query_item   = 3'd4;
    tick();
    chk("prio_busy_after_restock", 32'(busy), 32'd0);
    chk("prio_level_restocked", 32'(stock_level), 32'd20);
    restock_req = 1'b0;
    tick();
    chk("prio_busy_vend", 32'(busy), 32'd1);
    tick();
    chk("prio_ack", 32'(vend_ack), 32'd1);
    chk("prio_level_vended", 32'(stock_level), 32'd19);
    vend_req = 1'b0;
    tick();

    // Six-slot build: index 7 is out of range.
    d6_vend_item = 3'd7;
    d6_vend_req  = 1'b1;
    tick();
    tick();
    chk("d6_oor_nack", 32'(d6_vend_nack), 32'd1);
    chk("d6_oor_ack", 32'(d6_vend_ack), 32'd0);
    d6_vend_req = 1'b0;
    tick();
    d6_query_item = 3'd7;
    #1;
    chk("d6_oor_level", 32'(d6_stock_level), 32'd0);
    chk("d6_oor_sold_out", 32'(d6_sold_out), 32'd1);
    chk("d6_avail", 32'(d6_stock_available), 32'h3F);
    d6_vend_item = 3'd5;
    d6_vend_req  = 1'b1;
    tick();
    tick();
    chk("d6_inrange_ack", 32'(d6_vend_ack), 32'd1);
    d6_vend_req = 1'b0;
    tick();
    d6_query_item = 3'd5;
    #1;
    chk("d6_inrange_level", 32'(d6_stock_level), 32'd9);

    // Reset during CHECK aborts the vend.
    vend_item = 3'd1;
    vend_req  = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    chk("rst_no_resp", 32'({vend_ack, vend_nack}), 32'd0);
    vend_req = 1'b0;
    rst      = 1'b0;
    tick();
    chk("rst_no_resp_after", 32'({vend_ack, vend_nack}), 32'd0);
    query_item = 3'd1;
    #1;
    chk("rst_level_1", 32'(stock_level), 32'd10);
    query_item = 3'd3;
    #1;
    chk("rst_level_3", 32'(stock_level), 32'd10);
    chk("rst_ready", 32'(restock_ready), 32'd1);

`ifdef INVENTORY_AUDIT_EN
    query_item = 3'd0;
    #1;
    chk("audit_reset", 32'(audit_count), 32'd0);
    for (int k = 0; k < 3; k++) do_vend(0, 1'b1);
    tick();
    chk("audit_three", 32'(audit_count), 32'd3);
    query_item = 3'd1;
    #1;
    chk("audit_other", 32'(audit_count), 32'd0);
    query_item = 3'd0;
    audit_clr  = 1'b1;
    tick();
    audit_clr  = 1'b0;
    chk("audit_cleared", 32'(audit_count), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
